seg_scan_ctrl: RTL

- Memory-mapped, parametrised multi-digit seven-segment scan controller.
- Attaches to the CPU data bus (Read/Write/Address/Write_data/Read_data) alongside the UART inside Device.
- Drives the time-multiplexed sel/seg/dp pins.
- Generalises the fixed 4-digit display with configurable digit count, scan rate, pin polarity, per-digit blank/dp masks, leading-zero suppression and anti-ghost blanking.

---
 rtl/seg_scan_pkg.sv | 37 +++
 rtl/seg_scan_ctrl_if.sv | 20 ++
 rtl/seg_hex_decode.sv | 14 +
 rtl/seg_scan_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared definitions for the seven-segment scan controller: register offsets,
// CTRL field positions, the hex-to-segment table and dwell sizing helpers.
package seg_scan_pkg;

    localparam logic [31:0] DATA_OFS = 32'd0;
    localparam logic [31:0] CTRL_OFS = 32'd4;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_LZS_BIT   = 1;
    localparam int CTRL_DP_LSB    = 8;
    localparam int CTRL_BLANK_LSB = 16;
    localparam int CTRL_DUTY_LSB  = 28;

    // Segment patterns {g,f,e,d,c,b,a}, active-high, indexed by nibble value.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic int dwell_cycles(input int clk_freq, input int scan_hz);
        int d;
        d = clk_freq / scan_hz;
        if (d < 32'sd2) begin
            d = 32'sd2;
        end else begin
            d = d;
        end
        return d;
    endfunction

    function automatic int dwell_width(input int clk_freq, input int scan_hz);
        int w;
        w = $clog2(dwell_cycles(clk_freq, scan_hz));
        return (w < 32'sd1) ? 32'sd1 : w;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// CPU data-bus bundle shared by the scan controller (slave) and the bus owner (master).
interface seg_scan_ctrl_if;

    logic        Read;
    logic        Write;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic [31:0] Read_data;

    modport master (
        output Read, Write, Address, Write_data,
        input  Read_data
    );

    modport slave (
        input  Read, Write, Address, Write_data,
        output Read_data
    );

endinterface

// File: rtl/seg_hex_decode.sv
// Combinational nibble to seven-segment decoder, active-high {g,f,e,d,c,b,a}.
module seg_hex_decode
    import seg_scan_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    // Table lookup of the segment pattern.
    always_comb begin
        o_seg = HEX_SEG[i_nibble];
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Memory-mapped multi-digit seven-segment scan controller with DATA/CTRL registers.
// Optional brightness control via CTRL.DUTY is built when SEG_SCAN_DIM_EN is defined.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int          CLK_FREQ     = 110000000,
    parameter int          NUM_DIGITS   = 4,
    parameter int          SCAN_HZ      = 1000,
    parameter int          BLANK_CYCLES = 16,
    parameter logic [31:0] BASE_ADDR    = 32'h4000_0010,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    seg_scan_ctrl_if.slave        bus,
    output logic [NUM_DIGITS-1:0] sel,
    output logic [6:0]            seg,
    output logic                  dp
);

    localparam int DWELL  = dwell_cycles(CLK_FREQ, SCAN_HZ);
    localparam int DW     = dwell_width(CLK_FREQ, SCAN_HZ);
    localparam int IW     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BW_RAW = $clog2(BLANK_CYCLES + 1);
    localparam int BW     = (BW_RAW < 1) ? 1 : BW_RAW;
    localparam int NB     = 4 * NUM_DIGITS;

    logic [NB-1:0]         r_data;
    logic                  r_en;
    logic                  r_lzs;
    logic [NUM_DIGITS-1:0] r_dp_mask;
    logic [NUM_DIGITS-1:0] r_blank_mask;
`ifdef SEG_SCAN_DIM_EN
    logic [3:0]            r_duty;
    logic [3:0]            r_phase;
`endif

    logic [DW-1:0]         r_dwell;
    logic [IW-1:0]         r_idx;
    logic [BW-1:0]         r_blank;

    logic [NUM_DIGITS-1:0] r_sel_pin;
    logic [6:0]            r_seg_pin;
    logic                  r_dp_pin;

    logic                  w_hit_data;
    logic                  w_hit_ctrl;
    logic [31:0]           w_data_rd;
    logic [31:0]           w_ctrl_rd;
    logic [3:0]            w_nibble;
    logic [6:0]            w_hex;
    logic                  w_zero_run;
    logic                  w_lzs_dark;
    logic                  w_dark;
    logic                  w_lit;
    logic [NUM_DIGITS-1:0] w_sel;
    logic [6:0]            w_seg;
    logic                  w_dp;
    logic                  w_unused_wdata;

    assign w_hit_data     = (bus.Address == (BASE_ADDR + DATA_OFS));
    assign w_hit_ctrl     = (bus.Address == (BASE_ADDR + CTRL_OFS));
    assign w_unused_wdata = ^bus.Write_data;

    // Register read-back views and the combinational read mux.
    always_comb begin
        w_data_rd             = 32'd0;
        w_data_rd[NB-1:0]     = r_data;
        w_ctrl_rd             = 32'd0;
        w_ctrl_rd[CTRL_EN_BIT]  = r_en;
        w_ctrl_rd[CTRL_LZS_BIT] = r_lzs;
        w_ctrl_rd[CTRL_DP_LSB +: NUM_DIGITS]    = r_dp_mask;
        w_ctrl_rd[CTRL_BLANK_LSB +: NUM_DIGITS] = r_blank_mask;
`ifdef SEG_SCAN_DIM_EN
        w_ctrl_rd[CTRL_DUTY_LSB +: 4] = r_duty;
`endif
        if (bus.Read && w_hit_data) begin
            bus.Read_data = w_data_rd;
        end else if (bus.Read && w_hit_ctrl) begin
            bus.Read_data = w_ctrl_rd;
        end else begin
            bus.Read_data = 32'd0;
        end
    end

    // DATA and CTRL register writes; unimplemented bits are never stored.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data       <= '0;
            r_en         <= 1'b0;
            r_lzs        <= 1'b0;
            r_dp_mask    <= '0;
            r_blank_mask <= '0;
`ifdef SEG_SCAN_DIM_EN
            r_duty       <= 4'd0;
`endif
        end else begin
            if (bus.Write && w_hit_data) begin
                r_data <= bus.Write_data[NB-1:0];
            end
            if (bus.Write && w_hit_ctrl) begin
                r_en         <= bus.Write_data[CTRL_EN_BIT];
                r_lzs        <= bus.Write_data[CTRL_LZS_BIT];
                r_dp_mask    <= bus.Write_data[CTRL_DP_LSB +: NUM_DIGITS];
                r_blank_mask <= bus.Write_data[CTRL_BLANK_LSB +: NUM_DIGITS];
`ifdef SEG_SCAN_DIM_EN
                r_duty       <= bus.Write_data[CTRL_DUTY_LSB +: 4];
`endif
            end
        end
    end

    // Dwell / digit / anti-ghost timers; all parked at zero while disabled.
    always_ff @(posedge clk) begin
        if (reset || !r_en) begin
            r_dwell <= '0;
            r_idx   <= '0;
            r_blank <= '0;
        end else if (r_dwell == DW'(DWELL - 1)) begin
            r_dwell <= '0;
            r_idx   <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + 1'b1;
            r_blank <= BW'(BLANK_CYCLES);
        end else begin
            r_dwell <= r_dwell + 1'b1;
            if (r_blank != '0) begin
                r_blank <= r_blank - 1'b1;
            end
        end
    end

`ifdef SEG_SCAN_DIM_EN
    // Free-running PWM phase for the brightness duty window.
    always_ff @(posedge clk) begin
        if (reset || !r_en) begin
            r_phase <= 4'd0;
        end else begin
            r_phase <= r_phase + 4'd1;
        end
    end
`endif

    seg_hex_decode u_hex (
        .i_nibble (w_nibble),
        .o_seg    (w_hex)
    );

    // Leading-zero run: walk from the top digit down, capturing the run at the current index.
    always_comb begin
        w_zero_run = r_lzs;
        w_lzs_dark = 1'b0;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            w_zero_run = w_zero_run && (r_data[4*k +: 4] == 4'd0);
            w_lzs_dark = (IW'(k) == r_idx) ? w_zero_run : w_lzs_dark;
        end
    end

    // Next pin values, internal active-high view.
    always_comb begin
        w_nibble = r_data[{r_idx, 2'b00} +: 4];
        w_dark   = r_blank_mask[r_idx] || w_lzs_dark;
`ifdef SEG_SCAN_DIM_EN
        w_lit    = r_en && (r_blank == '0) && (r_phase <= r_duty);
`else
        w_lit    = r_en && (r_blank == '0);
`endif
        w_sel    = w_lit ? (NUM_DIGITS'(1'b1) << r_idx) : '0;
        w_seg    = (w_lit && !w_dark) ? w_hex : 7'd0;
        w_dp     = (w_lit && !w_dark) ? r_dp_mask[r_idx] : 1'b0;
    end

    // Registered pins with polarity applied.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sel_pin <= {NUM_DIGITS{ACTIVE_LOW}};
            r_seg_pin <= {7{ACTIVE_LOW}};
            r_dp_pin  <= ACTIVE_LOW;
        end else begin
            r_sel_pin <= w_sel ^ {NUM_DIGITS{ACTIVE_LOW}};
            r_seg_pin <= w_seg ^ {7{ACTIVE_LOW}};
            r_dp_pin  <= w_dp ^ ACTIVE_LOW;
        end
    end

    assign sel = r_sel_pin;
    assign seg = r_seg_pin;
    assign dp  = r_dp_pin;

endmodule
